// File: rtl/iccm_boot_arbiter.sv
// ICCM boot arbiter: owns the single-port ICCM macro. During BOOT the UART
// loader writes the image; after load completion a fixed guard interval
// elapses before the core is released and instruction fetch takes the port.
//
// state | meaning
// ------+----------------------------------------------------------------
// BOOT  | core held in reset, loader owns the SRAM, waiting for done edge
// HOLD  | SRAM idle, guard countdown of RST_HOLD cycles before release
// RUN   | core released, fetch requests granted straight to the SRAM
module iccm_boot_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 32,
   parameter int RST_HOLD = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ld_we_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_wdata_i,
   input  logic              ld_done_i,
   input  logic              rearm_i,
   input  logic              core_req_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [DATA_W-1:0] core_rdata_o,
   output logic              core_rst_no,
   output logic              mem_csb_o,
   output logic              mem_web_o,
   output logic [3:0]        mem_wmask_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              boot_busy_o,
   output logic [ADDR_W:0]   wr_count_o,
   output logic              ld_err_o
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   localparam logic [ADDR_W:0] WR_MAX    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [7:0]      HOLD_INIT = 8'(RST_HOLD - 1);

   state_e            state_q, state_d;
   logic [7:0]        hold_cnt_q;
   logic              ld_done_q;
   logic [ADDR_W:0]   wr_count_q;
   logic              ld_err_q;
   logic              core_rst_nq;
   logic              rvalid_q;

   logic              done_rise;
   logic              ld_wr;
   logic              fetch_gnt;
   logic              boot_entry;

   assign done_rise  = ld_done_i & ~ld_done_q;
   assign ld_wr      = (state_q == ST_BOOT) & ld_we_i;
   assign fetch_gnt  = (state_q == ST_RUN) & core_req_i;
   // Entering BOOT from anywhere else (rearm or illegal-encoding recovery)
   // starts a fresh load session.
   assign boot_entry = (state_d == ST_BOOT) & (state_q != ST_BOOT);

   // Next-state selection; unused encodings fall back to BOOT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: if (done_rise) state_d = ST_HOLD;
         ST_HOLD: begin
            if (rearm_i)                state_d = ST_BOOT;
            else if (hold_cnt_q == 8'd0) state_d = ST_RUN;
         end
         ST_RUN:  if (rearm_i) state_d = ST_BOOT;
         default: state_d = ST_BOOT;
      endcase
   end

   // SRAM port mux: loader writes in BOOT, fetch reads in RUN, idle otherwise.
   always_comb begin
      mem_csb_o   = ~(ld_wr | fetch_gnt);
      mem_web_o   = ~ld_wr;
      mem_wmask_o = ld_wr ? 4'hF : 4'h0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (ld_wr) begin
         mem_addr_o  = ld_addr_i;
         mem_wdata_o = ld_wdata_i;
      end else if (fetch_gnt) begin
         mem_addr_o  = core_addr_i;
      end
   end

   // State, guard counter, write count, error flag and registered core outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_BOOT;
         hold_cnt_q  <= 8'd0;
         ld_done_q   <= 1'b0;
         wr_count_q  <= '0;
         ld_err_q    <= 1'b0;
         core_rst_nq <= 1'b0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_done_q   <= ld_done_i;
         core_rst_nq <= (state_d == ST_RUN);
         rvalid_q    <= fetch_gnt;

         if (boot_entry)
            hold_cnt_q <= 8'd0;
         else if ((state_q == ST_BOOT) && done_rise)
            hold_cnt_q <= HOLD_INIT;
         else if ((state_q == ST_HOLD) && (hold_cnt_q != 8'd0))
            hold_cnt_q <= hold_cnt_q - 8'd1;

         if (boot_entry)
            wr_count_q <= '0;
         else if (ld_wr && (wr_count_q != WR_MAX))
            wr_count_q <= wr_count_q + 1'b1;

         if (boot_entry)
            ld_err_q <= 1'b0;
         else if (ld_we_i && (state_q != ST_BOOT))
            ld_err_q <= 1'b1;
      end
   end

   assign core_gnt_o    = fetch_gnt;
   assign core_rvalid_o = rvalid_q;
   assign core_rdata_o  = mem_rdata_i;
   assign core_rst_no   = core_rst_nq;
   assign boot_busy_o   = ~core_rst_nq;
   assign wr_count_o    = wr_count_q;
   assign ld_err_o      = ld_err_q;

endmodule

// File: tb/tb_iccm_boot_arbiter.sv
// Bench for iccm_boot_arbiter: behavioural SRAM, reference image memory,
// and a due-cycle scoreboard for fetch responses.
module tb_iccm_boot_arbiter;

   localparam int ADDR_W   = 14;
   localparam int DATA_W   = 32;
   localparam int RST_HOLD = 16;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              ld_we_i;
   logic [ADDR_W-1:0] ld_addr_i;
   logic [DATA_W-1:0] ld_wdata_i;
   logic              ld_done_i;
   logic              rearm_i;
   logic              core_req_i;
   logic [ADDR_W-1:0] core_addr_i;
   logic              core_gnt_o;
   logic              core_rvalid_o;
   logic [DATA_W-1:0] core_rdata_o;
   logic              core_rst_no;
   logic              mem_csb_o;
   logic              mem_web_o;
   logic [3:0]        mem_wmask_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              boot_busy_o;
   logic [ADDR_W:0]   wr_count_o;
   logic              ld_err_o;

   iccm_boot_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_HOLD(RST_HOLD)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
      .ld_done_i(ld_done_i), .rearm_i(rearm_i),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i),
      .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
      .core_rdata_o(core_rdata_o), .core_rst_no(core_rst_no),
      .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o), .mem_wmask_o(mem_wmask_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .boot_busy_o(boot_busy_o), .wr_count_o(wr_count_o), .ld_err_o(ld_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                due;
   } exp_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int sram_wr = 0;
   int exp_sram_wr = 0;
   int exp_count = 0;

   logic [DATA_W-1:0] sram    [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
   logic [ADDR_W-1:0] addr_list[$];
   exp_t              exp_q[$];

   always @(posedge clk_i) cyc <= cyc + 1;

   // Behavioural single-port SRAM with one-cycle read latency.
   always @(posedge clk_i) begin
      if (mem_csb_o === 1'b0) begin
         if (mem_web_o === 1'b0) begin
            sram[mem_addr_o] = mem_wdata_o;
            sram_wr = sram_wr + 1;
         end else begin
            mem_rdata_i <= sram.exists(mem_addr_o) ? sram[mem_addr_o] : 32'hBAD0BAD0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Response monitor: a fetch granted in cycle c must return in cycle c+1.
   always @(negedge clk_i) begin : mon
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         chk("rvalid", {63'd0, core_rvalid_o}, 64'd1);
         chk("rdata", {32'd0, core_rdata_o}, {32'd0, e.data});
      end else if (rst_ni === 1'b1 && core_rvalid_o !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL rvalid_spurious actual=%b required=0 cyc=%0d", core_rvalid_o, cyc);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One loader write in BOOT, with the core requesting a random address.
   task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      ld_we_i     = 1'b1;
      ld_addr_i   = a;
      ld_wdata_i  = d;
      core_req_i  = 1'b1;
      core_addr_i = ADDR_W'($urandom);
      #2;
      chk("ld_port", {mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o},
          {1'b0, 1'b0, 4'hF, a});
      chk("ld_wdata", {32'd0, mem_wdata_o}, {32'd0, d});
      chk("boot_gnt", {63'd0, core_gnt_o}, 64'd0);
      ref_mem[a] = d;
      exp_count++;
      exp_sram_wr++;
      tick();
      ld_we_i = 1'b0;
   endtask

   // Count cycles with the core held after done is raised; optional illegal write.
   task automatic measure_hold(input int inject);
      int n = 0;
      tick();
      while (core_rst_no === 1'b0 && n < 300) begin
         n++;
         if (n == inject) begin
            ld_we_i    = 1'b1;
            ld_addr_i  = 5;
            ld_wdata_i = $urandom;
            #2;
            chk("hold_wr_dropped", {63'd0, mem_csb_o}, 64'd1);
         end
         tick();
         ld_we_i = 1'b0;
      end
      chk("hold_len", n, RST_HOLD);
      chk("run_busy", {63'd0, boot_busy_o}, 64'd0);
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a);
      core_req_i  = 1'b1;
      core_addr_i = a;
      exp_q.push_back('{data: ref_mem[a], due: cyc + 1});
      #2;
      chk("fetch_port", {core_gnt_o, mem_csb_o, mem_web_o, mem_wmask_o, mem_addr_o},
          {1'b1, 1'b0, 1'b1, 4'h0, a});
      tick();
      core_req_i = 1'b0;
   endtask

   task automatic chk_reset_vals(input string name);
      chk(name, {core_rst_no, core_gnt_o, core_rvalid_o, boot_busy_o,
                 mem_csb_o, mem_web_o, mem_wmask_o, ld_err_o},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0});
      chk({name, "_addr"}, {50'd0, mem_addr_o}, 64'd0);
      chk({name, "_wdata"}, {32'd0, mem_wdata_o}, 64'd0);
      chk({name, "_wrcnt"}, {49'd0, wr_count_o}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      rst_ni = 1'b0; ld_we_i = 0; ld_addr_i = 0; ld_wdata_i = 0; ld_done_i = 0;
      rearm_i = 0; core_req_i = 0; core_addr_i = 0;
      #3;
      chk_reset_vals("reset");
      tick();
      tick();
      rst_ni = 1'b1;

      // Boot load with the core requesting throughout BOOT.
      load_word(0, 32'hDEADBEEF);
      load_word(1, 32'h12345678);
      load_word(2, 32'h00000013);
      chk("wr_count3", {49'd0, wr_count_o}, 64'd3);
      addr_list = '{0, 1, 2, 5};
      load_word(5, 32'h5A5A0005);
      for (int i = 0; i < 6; i++) begin
         a = ADDR_W'($urandom_range(63, 8));
         d = $urandom;
         addr_list.push_back(a);
         load_word(a, d);
      end
      chk("wr_count_load", {49'd0, wr_count_o}, exp_count);
      chk("sram_wr_load", sram_wr, exp_sram_wr);
      core_req_i = 1'b0;
      ld_done_i  = 1'b1;
      measure_hold(7);
      chk("err_after_hold", {63'd0, ld_err_o}, 64'd1);

      // Fixed fetches, then an illegal write in RUN, then random fetches.
      fetch(0);
      fetch(1);
      fetch(2);
      ld_we_i = 1'b1; ld_addr_i = 5; ld_wdata_i = 32'hFFFF0000;
      #2;
      chk("run_wr_dropped", {63'd0, mem_csb_o}, 64'd1);
      tick();
      ld_we_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            fetch(addr_list[$urandom_range(addr_list.size() - 1, 0)]);
         end else begin
            #2;
            chk("idle_gnt", {63'd0, core_gnt_o}, 64'd0);
            tick();
         end
      end
      fetch(5);
      chk("err_sticky", {63'd0, ld_err_o}, 64'd1);
      chk("sram_wr_run", sram_wr, exp_sram_wr);

      // Rearm in the same cycle as a granted fetch; ld_done_i still high.
      rearm_i = 1'b1;
      fetch(1);
      rearm_i    = 1'b0;
      core_req_i = 1'b1;
      #1;
      chk("rearm_state", {core_rst_no, ld_err_o, core_gnt_o}, 3'b000);
      chk("rearm_wrcnt", {49'd0, wr_count_o}, 64'd0);
      chk("rearm_rvalid", {63'd0, core_rvalid_o}, 64'd1);
      for (int i = 0; i < 20; i++) tick();
      chk("level_no_exit", {core_rst_no, boot_busy_o, core_rvalid_o}, 3'b010);
      ld_done_i = 1'b0;
      exp_count = 0;
      tick();
      load_word(0, 32'hC0FFEE00);
      load_word(1, 32'h0BADF00D);
      chk("reload_wrcnt", {49'd0, wr_count_o}, exp_count);
      core_req_i = 1'b0;
      ld_done_i  = 1'b1;
      measure_hold(0);
      chk("reload_err", {63'd0, ld_err_o}, 64'd0);
      fetch(0);
      fetch(1);

      // Reset during HOLD cycle 7.
      rearm_i = 1'b1;
      tick();
      rearm_i   = 1'b0;
      ld_done_i = 1'b0;
      tick();
      ld_done_i = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("pre_reset_hold", {63'd0, core_rst_no}, 64'd0);
      #2;
      ld_done_i = 1'b0;
      rst_ni    = 1'b0;
      #1;
      chk_reset_vals("hold_reset");
      tick();
      rst_ni = 1'b1;
      exp_count = 0;
      tick();
      a = ADDR_W'($urandom_range(200, 100));
      load_word(a, $urandom);
      chk("post_rst_wrcnt", {49'd0, wr_count_o}, exp_count);
      ld_done_i = 1'b1;
      measure_hold(0);
      fetch(a);
      fetch(2);

      tick();
      tick();
      chk("sram_wr_final", sram_wr, exp_sram_wr);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
